// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment hex display driver with per-frame value snapshot.
// Optional macro SEG7_LEADING_ZERO_BLANK_EN auto-blanks leading zero digits.
module seg7_scan_driver #(
  parameter int unsigned DIGITS      = 8,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                  clock_i,
  input  logic                  clear_i,
  input  logic                  enable_i,
  input  logic [4*DIGITS-1:0]   value_i,
  input  logic [DIGITS-1:0]     blank_mask_i,
  input  logic [DIGITS-1:0]     dp_mask_i,
  output logic [DIGITS-1:0]     anode_o,
  output logic [6:0]            segments_o,
  output logic                  dp_o,
  output logic                  frame_done_o
);

  localparam int unsigned CntW = $clog2(REFRESH_DIV);
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);
  localparam logic [IdxW-1:0] IdxMax = IdxW'(DIGITS - 1);

  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [4*DIGITS-1:0] snap_q, snap_d;
  logic                frame_done_q, frame_done_d;
  logic [DIGITS-1:0]   anode_q, anode_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;

  logic [3:0] nib;
  logic       blank_sel;
  logic       dp_sel;
  logic       auto_blank;

  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0000100;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b1100000;
      4'hC:    s = 7'b0110001;
      4'hD:    s = 7'b1000010;
      4'hE:    s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // Scan timing and frame-start snapshot.
  always_comb begin
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    snap_d       = snap_q;
    frame_done_d = 1'b0;
    if (enable_i) begin
      if (cnt_q == '0 && idx_q == '0) begin
        snap_d = value_i;
      end
      if (cnt_q == CntMax) begin
        cnt_d = '0;
        if (idx_q == IdxMax) begin
          idx_d        = '0;
          frame_done_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Digit decode uses the held snapshot but live masks.
  always_comb begin
    nib        = 4'h0;
    blank_sel  = 1'b0;
    dp_sel     = 1'b0;
    auto_blank = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_q == IdxW'(i)) begin
        nib       = snap_q[4*i +: 4];
        blank_sel = blank_mask_i[i];
        dp_sel    = dp_mask_i[i];
      end
    end
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    begin
      logic upper_zero;
      upper_zero = 1'b1;
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (IdxW'(i) >= idx_q && snap_q[4*i +: 4] != 4'h0) begin
          upper_zero = 1'b0;
        end
      end
      auto_blank = (idx_q != '0) && !dp_sel && upper_zero;
    end
`endif
    anode_d = ~(DIGITS'(1) << idx_q);
    seg_d   = (blank_sel || auto_blank) ? 7'b1111111 : hex_seg(nib);
    dp_d    = ~dp_sel;
  end

  always_ff @(posedge clock_i) begin
    if (clear_i) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      snap_q       <= '0;
      frame_done_q <= 1'b0;
      anode_q      <= '1;
      seg_q        <= 7'b1111111;
      dp_q         <= 1'b1;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      snap_q       <= snap_d;
      frame_done_q <= frame_done_d;
      anode_q      <= anode_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign anode_o      = anode_q;
  assign segments_o   = seg_q;
  assign dp_o         = dp_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter DIGITS, default 8: number of time-multiplexed digits; legal range 1..16.
REQ-002 Parameter REFRESH_DIV, default 100000: clock cycles each digit is displayed; legal range 2 or greater.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 clear  input  1  reset; synchronous and active-high.
REQ-005 enable  input  1  scan advance enable.
REQ-006 value  input  4*DIGITS  hex nibbles; nibble i = value[4i+3:4i]; digit 0 is rightmost (least significant).
REQ-007 blank_mask  input  DIGITS  1 = force digit i dark.
REQ-008 dp_mask  input  DIGITS  1 = light the decimal point on digit i.
REQ-009 anode  output  DIGITS  active-low digit select; one-hot-low or all ones.
REQ-010 segments  output  7  active-low, bit order {a,b,c,d,e,f,g}.
REQ-011 dp  output  1  active-low decimal point.
REQ-012 frame_done  output  1  one-cycle pulse per completed scan frame.

Function
REQ-013 The block SHALL hold a divider counter (0..REFRESH_DIV-1) and a digit index (0..DIGITS-1), both advancing only while enable=1.
REQ-014 The counter SHALL increment each enabled cycle and wrap from REFRESH_DIV-1 to 0; on that wrap the digit index SHALL increment, wrapping from DIGITS-1 to 0.
REQ-015 frame_done SHALL be 1 for exactly the one cycle following the edge on which the digit index wraps DIGITS-1 -> 0, and 0 otherwise.
REQ-016 The block SHALL keep a snapshot register, loaded from value on every enabled edge where counter=0 and digit index=0 (frame start); display SHALL use the snapshot only, so mid-frame value changes appear from the next frame.
REQ-017 blank_mask and dp_mask SHALL be used live, not snapshotted.
REQ-018 anode, segments and dp SHALL be registered: each edge they take the decode of the current digit index and snapshot (one-cycle latency).
REQ-019 The selected digit SHALL drive its anode bit to 0 and all other anode bits to 1.
REQ-020 Hex decode (segments): 0=0000001 1=1001111 2=0010010 3=0000110 4=1001100 5=0100100 6=0100000 7=0001111 8=0000000 9=0000100 A=0001000 b=1100000 C=0110001 d=1000010 E=0110000 F=0111000.
REQ-021 A blanked digit SHALL keep its anode asserted and drive segments=1111111; dp SHALL still follow dp_mask.
REQ-022 dp SHALL be 0 when dp_mask[index]=1, else 1.
REQ-023 With enable=0, counter, index and snapshot SHALL hold; outputs SHALL keep refreshing the held digit, tracking blank_mask and dp_mask changes.
REQ-024 With DIGITS=1, the index SHALL stay 0 and frame_done SHALL pulse once per REFRESH_DIV enabled cycles.

Reset
REQ-025 On a clock edge with clear=1, regardless of enable, the block SHALL set counter=0, index=0, snapshot=0, anode=all ones, segments=1111111, dp=1, frame_done=0.
REQ-026 Clear mid-frame SHALL abandon the frame with no frame_done pulse; scanning SHALL restart at digit 0 with a fresh snapshot on the first enabled cycle.

Configuration
REQ-027 Macro SEG7_LEADING_ZERO_BLANK_EN defined: digit i>0 SHALL be blanked as in REQ-021 when snapshot nibbles i..DIGITS-1 are all zero and dp_mask[i]=0; digit 0 SHALL never be auto-blanked; this blanking SHALL be ORed with blank_mask.
REQ-028 Macro undefined: no automatic blanking; zeros SHALL display as 0000001.

Verification (DIGITS=4, REFRESH_DIV=4)
REQ-029 Clear, then enable=1 with value=16'h1234 -> on the 2nd cycle after clear drops: anode=1110, segments=1001100; 4 cycles later: anode=1101, segments=0000110.
REQ-030 value=16'hBDEF, full frame -> digit 0: 0111000, digit 1: 0110000, digit 2: 1000010, digit 3: 1100000; frame_done high for one cycle after the wrap (16 enabled cycles per frame).
REQ-031 enable=0 for 10 cycles mid-digit -> anode and segments stable; a value change during the frame is not shown until the next frame start.
REQ-032 blank_mask=4'b0100, dp_mask=4'b0100 -> while anode=1011: segments=1111111, dp=0.
REQ-033 value=16'h0042 -> with SEG7_LEADING_ZERO_BLANK_EN, digits 3 and 2 show 1111111; without it, they show 0000001.
REQ-034 clear asserted mid-frame at index 2 -> next cycle: anode=1111, segments=1111111, dp=1, frame_done=0.
